// File: rtl/playfield_commit_ctrl.sv
// Tear-free playfield commit controller: shadow rows are written freely, then copied to display_data one row per cycle during vertical blank.
// Optional feature macro: PF_COMMIT_COUNT_EN adds a wrapping 16-bit commit_count output.
package DisplayPkg;
  localparam int PLAYFIELD_ROWS = 20;
  localparam int PLAYFIELD_COLS = 10;
  typedef enum logic [2:0] {BLANK, I, O, T, S, Z, J, L} tile_type_t;
endpackage

module playfield_commit_ctrl
  import DisplayPkg::*;
#(
  parameter int VBLANK_ROW = 480
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic [9:0]                                          VGA_row,
  input  logic                                                wr_valid,
  output logic                                                wr_ready,
  input  logic [4:0]                                          wr_row,
  input  tile_type_t [PLAYFIELD_COLS-1:0]                     wr_data,
  input  logic                                                commit_req,
  output logic                                                commit_ack,
  output logic                                                busy,
  output tile_type_t [PLAYFIELD_ROWS-1:0][PLAYFIELD_COLS-1:0] display_data
`ifdef PF_COMMIT_COUNT_EN
  ,
  output logic [15:0]                                         commit_count
`endif
);

  typedef enum logic [1:0] {IDLE, PENDING, COPY, DONE} state_t;

  localparam logic [4:0] LAST_ROW = 5'(PLAYFIELD_ROWS - 1);
  localparam logic [9:0] VBLANK   = 10'(VBLANK_ROW);

  state_t state, state_next;
  logic [4:0] copy_cnt;
  tile_type_t [PLAYFIELD_ROWS-1:0][PLAYFIELD_COLS-1:0] shadow;

  logic in_vblank;
  logic wr_fire;
  logic wr_in_range;

  assign in_vblank   = (VGA_row >= VBLANK);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (wr_row <= LAST_ROW);

  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    commit_ack = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        busy     = 1'b0;
        if (commit_req) state_next = PENDING;
      end
      PENDING: begin
        if (in_vblank) state_next = COPY;
      end
      COPY: begin
        if (copy_cnt == LAST_ROW) state_next = DONE;
      end
      DONE: begin
        commit_ack = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The counter is cleared while pending so every copy starts at row 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      copy_cnt <= '0;
    end else if (state == COPY) begin
      copy_cnt <= (copy_cnt == LAST_ROW) ? 5'd0 : copy_cnt + 5'd1;
    end else if (state == PENDING) begin
      copy_cnt <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < PLAYFIELD_ROWS; r++)
        for (int c = 0; c < PLAYFIELD_COLS; c++)
          shadow[r][c] <= BLANK;
    end else if (wr_fire && wr_in_range) begin
      shadow[wr_row] <= wr_data;
    end
  end

  // Only the COPY state touches the display, so it cannot change mid-frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < PLAYFIELD_ROWS; r++)
        for (int c = 0; c < PLAYFIELD_COLS; c++)
          display_data[r][c] <= BLANK;
    end else if (state == COPY) begin
      display_data[copy_cnt] <= shadow[copy_cnt];
    end
  end

`ifdef PF_COMMIT_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           commit_count <= '0;
    else if (commit_ack) commit_count <= commit_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_playfield_commit_ctrl.sv
// Randomized self-checking bench for playfield_commit_ctrl against a frame-level shadow/display model.
// Define PF_COMMIT_COUNT_EN to also exercise the commit_count output.
module tb_playfield_commit_ctrl;
  import DisplayPkg::*;

  typedef tile_type_t [PLAYFIELD_COLS-1:0] row_t;

  logic       clock;
  logic       reset;
  logic [9:0] VGA_row;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_row;
  row_t       wr_data;
  logic       commit_req;
  logic       commit_ack;
  logic       busy;
  tile_type_t [PLAYFIELD_ROWS-1:0][PLAYFIELD_COLS-1:0] display_data;
`ifdef PF_COMMIT_COUNT_EN
  logic [15:0] commit_count;
  int          model_count;
`endif

  row_t model_shadow  [PLAYFIELD_ROWS];
  row_t model_display [PLAYFIELD_ROWS];

  int tests_run;
  int tests_failed;

  playfield_commit_ctrl #(.VBLANK_ROW(480)) dut (
    .clock        (clock),
    .reset        (reset),
    .VGA_row      (VGA_row),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .commit_req   (commit_req),
    .commit_ack   (commit_ack),
    .busy         (busy),
    .display_data (display_data)
`ifdef PF_COMMIT_COUNT_EN
    ,
    .commit_count (commit_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic row_t fill_row(input tile_type_t t);
    row_t r;
    for (int c = 0; c < PLAYFIELD_COLS; c++) r[c] = t;
    return r;
  endfunction

  function automatic row_t random_row();
    row_t r;
    for (int c = 0; c < PLAYFIELD_COLS; c++) r[c] = tile_type_t'(3'($urandom_range(0, 7)));
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    wr_valid   = 1'b0;
    wr_row     = '0;
    wr_data    = fill_row(BLANK);
    commit_req = 1'b0;
    VGA_row    = 10'd0;
    step();
    step();
    reset = 1'b0;
    for (int r = 0; r < PLAYFIELD_ROWS; r++) begin
      model_shadow[r]  = fill_row(BLANK);
      model_display[r] = fill_row(BLANK);
    end
`ifdef PF_COMMIT_COUNT_EN
    model_count = 0;
`endif
  endtask

  task automatic do_write(input logic [4:0] row, input row_t data);
    int guard = 0;
    while (!wr_ready && guard < 100) begin
      step();
      guard++;
    end
    wr_valid = 1'b1;
    wr_row   = row;
    wr_data  = data;
    step();
    wr_valid = 1'b0;
    if (int'(row) < PLAYFIELD_ROWS) model_shadow[row] = data;
  endtask

  task automatic pulse_commit(input logic [9:0] vga);
    VGA_row    = vga;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
  endtask

  // A finished commit makes the display equal to the shadow frame.
  task automatic wait_ack(input int budget, output int cycles, output bit got);
    cycles = 0;
    got    = 1'b0;
    while (cycles < budget) begin
      step();
      cycles++;
      if (commit_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      for (int r = 0; r < PLAYFIELD_ROWS; r++) model_display[r] = model_shadow[r];
`ifdef PF_COMMIT_COUNT_EN
      model_count = (model_count + 1) % 65536;
`endif
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    apply_reset();
    tests_run++;
    if ({wr_ready, commit_ack, busy} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: ready/ack/busy=%b expected 100", {wr_ready, commit_ack, busy});
    end
    for (int r = 0; r < PLAYFIELD_ROWS; r++) if (display_data[r] !== fill_row(BLANK)) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_display: %0d non-blank rows, expected 0", bad);
    end
`ifdef PF_COMMIT_COUNT_EN
    tests_run++;
    if (commit_count !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count: got %0d expected 0", commit_count);
    end
`endif
  endtask

  task automatic test_active_video_commit();
    int cycles;
    bit got;
    int bad = 0;
    apply_reset();
    do_write(5'd3, fill_row(T));
    pulse_commit(10'd100);
    for (int k = 0; k < 40; k++) begin
      step();
      for (int r = 0; r < PLAYFIELD_ROWS; r++) if (display_data[r] !== model_display[r]) bad++;
      if (!busy || commit_ack) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL active_video_hold: %0d changes during active video, expected 0", bad);
    end
    VGA_row = 10'd480;
    wait_ack(30, cycles, got);
    tests_run++;
    if (!got || cycles != 21) begin
      tests_failed++;
      $display("[TB] FAIL blank_start_latency: got=%0d cycles=%0d expected ack after 21", got, cycles);
    end
    tests_run++;
    if (display_data[3] !== fill_row(T)) begin
      tests_failed++;
      $display("[TB] FAIL row3_copied: got %h expected %h", display_data[3], fill_row(T));
    end
    step();
    tests_run++;
    if (commit_ack !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ack_single_pulse: ack=%b expected 0", commit_ack);
    end
  endtask

  task automatic test_blank_latency();
    int cycles;
    bit got;
    int bad = 0;
    apply_reset();
    do_write(5'd5, fill_row(L));
    pulse_commit(10'd490);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL busy_next_cycle: busy=%b expected 1", busy);
    end
    wait_ack(40, cycles, got);
    tests_run++;
    if (!got || cycles + 1 != PLAYFIELD_ROWS + 2) begin
      tests_failed++;
      $display("[TB] FAIL commit_latency: got=%0d cycles=%0d expected %0d", got, cycles + 1, PLAYFIELD_ROWS + 2);
    end
    for (int r = 0; r < PLAYFIELD_ROWS; r++) if (display_data[r] !== model_display[r]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL blank_commit_rows: %0d rows differ from model, expected 0", bad);
    end
  endtask

  task automatic test_write_stall();
    int cycles;
    bit got;
    int bad = 0;
    apply_reset();
    pulse_commit(10'd100);
    wr_valid = 1'b1;
    wr_row   = 5'd2;
    wr_data  = fill_row(S);
    for (int k = 0; k < 5; k++) begin
      if (wr_ready !== 1'b0) bad++;
      step();
    end
    VGA_row = 10'd480;
    wait_ack(40, cycles, got);
    if (wr_ready !== 1'b0) bad++;
    tests_run++;
    if (!got || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL write_stall: got=%0d ready_violations=%0d expected ack and 0", got, bad);
    end
    tests_run++;
    if (display_data[2] !== fill_row(BLANK)) begin
      tests_failed++;
      $display("[TB] FAIL stalled_write_excluded: row2=%h expected %h", display_data[2], fill_row(BLANK));
    end
    step();
    tests_run++;
    if (wr_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ready_after_ack: wr_ready=%b expected 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    model_shadow[2] = fill_row(S);
    pulse_commit(10'd480);
    wait_ack(40, cycles, got);
    tests_run++;
    if (!got || display_data[2] !== fill_row(S)) begin
      tests_failed++;
      $display("[TB] FAIL stalled_write_lands: got=%0d row2=%h expected %h", got, display_data[2], fill_row(S));
    end
  endtask

  task automatic test_out_of_range();
    int cycles;
    bit got;
    int bad = 0;
    apply_reset();
    do_write(5'd7, fill_row(Z));
    tests_run++;
    if (wr_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL oor_handshake: wr_ready=%b expected 1", wr_ready);
    end
    do_write(5'd25, fill_row(I));
    pulse_commit(10'd500);
    wait_ack(40, cycles, got);
    for (int r = 0; r < PLAYFIELD_ROWS; r++) if (display_data[r] !== model_display[r]) bad++;
    tests_run++;
    if (!got || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL out_of_range_write: got=%0d rows_wrong=%0d expected ack and 0", got, bad);
    end
  endtask

  task automatic test_reset_mid_copy();
    int cycles;
    bit got;
    int bad = 0;
    apply_reset();
    for (int r = 0; r < PLAYFIELD_ROWS; r++) do_write(5'(r), fill_row(J));
    pulse_commit(10'd490);
    repeat (11) step();
    tests_run++;
    if (display_data[0] !== fill_row(J) || display_data[15] !== fill_row(BLANK)) begin
      tests_failed++;
      $display("[TB] FAIL copy_in_progress: row0=%h row15=%h expected %h / %h",
               display_data[0], display_data[15], fill_row(J), fill_row(BLANK));
    end
    reset = 1'b1;
    #1;
    for (int r = 0; r < PLAYFIELD_ROWS; r++) if (display_data[r] !== fill_row(BLANK)) bad++;
    tests_run++;
    if (bad != 0 || {wr_ready, commit_ack, busy} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_copy: nonblank=%0d ready/ack/busy=%b expected 0 and 100",
               bad, {wr_ready, commit_ack, busy});
    end
    step();
    apply_reset();
    pulse_commit(10'd490);
    wait_ack(40, cycles, got);
    bad = 0;
    for (int r = 0; r < PLAYFIELD_ROWS; r++) if (display_data[r] !== fill_row(BLANK)) bad++;
    tests_run++;
    if (!got || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL shadow_cleared: got=%0d nonblank=%0d expected ack and 0", got, bad);
    end
  endtask

  task automatic test_commit_ignored();
    int cycles;
    bit got;
    int extra = 0;
    apply_reset();
    do_write(5'd9, fill_row(O));
    pulse_commit(10'd200);
    step();
    pulse_commit(10'd200);
    VGA_row = 10'd481;
    wait_ack(40, cycles, got);
    for (int k = 0; k < 30; k++) begin
      step();
      if (commit_ack || busy) extra++;
    end
    tests_run++;
    if (!got || extra != 0) begin
      tests_failed++;
      $display("[TB] FAIL commit_ignored_when_busy: got=%0d extra_busy_cycles=%0d expected ack and 0", got, extra);
    end
  endtask

  task automatic test_random();
    int cycles;
    bit got;
    int bad;
    int nwr;
    bit in_blank;
    apply_reset();
    for (int it = 0; it < 8; it++) begin
      bad = 0;
      nwr = $urandom_range(2, 6);
      for (int w = 0; w < nwr; w++) do_write(5'($urandom_range(0, 24)), random_row());
      in_blank = ($urandom_range(0, 1) == 1);
      if (in_blank) begin
        pulse_commit(10'($urandom_range(480, 524)));
      end else begin
        pulse_commit(10'($urandom_range(0, 479)));
        repeat ($urandom_range(1, 8)) begin
          step();
          for (int r = 0; r < PLAYFIELD_ROWS; r++) if (display_data[r] !== model_display[r]) bad++;
        end
        VGA_row = 10'($urandom_range(480, 524));
      end
      wait_ack(60, cycles, got);
      if (in_blank && cycles + 1 != PLAYFIELD_ROWS + 2) bad++;
      for (int r = 0; r < PLAYFIELD_ROWS; r++) if (display_data[r] !== model_display[r]) bad++;
      tests_run++;
      if (!got || bad != 0) begin
        tests_failed++;
        $display("[TB] FAIL random_commit_%0d: got=%0d errors=%0d expected ack and 0", it, got, bad);
      end
`ifdef PF_COMMIT_COUNT_EN
      step();
      tests_run++;
      if (commit_count !== 16'(model_count)) begin
        tests_failed++;
        $display("[TB] FAIL commit_count_%0d: got %0d expected %0d", it, commit_count, model_count);
      end
`endif
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_active_video_commit();
    test_blank_latency();
    test_write_stall();
    test_out_of_range();
    test_reset_mid_copy();
    test_commit_ignored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
